ex_div: RTL and testbench

EX_DIV -- requirements
Module: ex_div

---
 rtl/ex_div.sv | 166 ++++++++++++++++
 tb/tb_ex_div.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// ex_div: multi-cycle 32-bit integer divider for the EX stage (DIV/DIVU/REM/REMU).
// Restoring radix-2 core that produces one quotient bit per cycle.
// Optional build macro DIV_EARLY_OUT_EN: finishes in one cycle when |divisor| > |dividend|.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start_i,
    input  logic        div_signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        annul_i,
    input  logic        hold_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ZERO = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] quo;        // shifts dividend out, quotient bits in
    logic [DATA_W-1:0] rem;        // partial remainder
    logic [DATA_W-1:0] dvsr;       // divisor magnitude
    logic [DATA_W-1:0] dvnd_orig;  // dividend as presented, for zero/early paths
    logic              neg_q;
    logic              neg_r;

    logic [DATA_W-1:0] dvnd_abs_c;
    logic [DATA_W-1:0] dvsr_abs_c;
    logic              accept_c;
    logic              dvsr_zero_c;
    logic              early_c;
    logic [DATA_W:0]   partial_c;
    logic [DATA_W:0]   trial_c;
    logic              q_bit_c;
    logic [DATA_W-1:0] quo_step_c;
    logic [DATA_W-1:0] rem_step_c;
    logic [DATA_W-1:0] quo_fix_c;
    logic [DATA_W-1:0] rem_fix_c;

    // Operand magnitudes; 0x80000000 maps to itself as an unsigned value
    assign dvnd_abs_c  = (div_signed_i && dividend_i[DATA_W-1]) ? DATA_W'(-dividend_i) : dividend_i;
    assign dvsr_abs_c  = (div_signed_i && divisor_i[DATA_W-1])  ? DATA_W'(-divisor_i)  : divisor_i;
    assign accept_c    = (state == S_IDLE) && div_start_i && !annul_i;
    assign dvsr_zero_c = (divisor_i == '0);

`ifdef DIV_EARLY_OUT_EN
    assign early_c = !dvsr_zero_c && (dvsr_abs_c > dvnd_abs_c);
`else
    assign early_c = 1'b0;
`endif

    // One restoring step: shift in next dividend bit, subtract if it fits
    assign partial_c  = {rem, quo[DATA_W-1]};
    assign trial_c    = partial_c - {1'b0, dvsr};
    assign q_bit_c    = !trial_c[DATA_W];
    assign rem_step_c = q_bit_c ? trial_c[DATA_W-1:0] : partial_c[DATA_W-1:0];
    assign quo_step_c = {quo[DATA_W-2:0], q_bit_c};

    // Sign correction applied on the final step as the result enters DONE
    assign quo_fix_c = neg_q ? DATA_W'(-quo_step_c) : quo_step_c;
    assign rem_fix_c = neg_r ? DATA_W'(-rem_step_c) : rem_step_c;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; annul overrides start and hold
    always_comb begin
        state_nxt = state;
        if (annul_i) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (div_start_i) begin
                        if (dvsr_zero_c)  state_nxt = S_ZERO;
                        else if (early_c) state_nxt = S_DONE;
                        else              state_nxt = S_BUSY;
                    end
                end
                S_ZERO:  state_nxt = S_DONE;
                S_BUSY:  if (cnt == LAST_ITER) state_nxt = S_DONE;
                S_DONE:  if (!hold_i) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath: operand capture, iteration, result load
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            quo       <= '0;
            rem       <= '0;
            dvsr      <= '0;
            dvnd_orig <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else if (annul_i) begin
            cnt <= '0;
            quo <= '0;
            rem <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        dvsr      <= dvsr_abs_c;
                        dvnd_orig <= dividend_i;
                        neg_q     <= div_signed_i && (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
                        neg_r     <= div_signed_i && dividend_i[DATA_W-1];
                        cnt       <= '0;
                        if (early_c) begin
                            quo <= '0;
                            rem <= dividend_i;
                        end else begin
                            quo <= dvnd_abs_c;
                            rem <= '0;
                        end
                    end
                end
                S_ZERO: begin
                    quo <= '1;
                    rem <= dvnd_orig;
                end
                S_BUSY: begin
                    if (cnt == LAST_ITER) begin
                        cnt <= '0;
                        quo <= quo_fix_c;
                        rem <= rem_fix_c;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        quo <= quo_step_c;
                        rem <= rem_step_c;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result presentation, zero outside DONE
    assign ready_o     = (state == S_DONE);
    assign quotient_o  = ready_o ? quo : '0;
    assign remainder_o = ready_o ? rem : '0;

    // Pipeline stall request, asserted already in the accepting cycle
    assign stallreq_o  = div_start_i && !annul_i && (state != S_DONE);

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed self-checking bench for ex_div.
// Honours DIV_EARLY_OUT_EN to pick the expected latency of early-out cases.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start_i;
    logic        div_signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        annul_i;
    logic        hold_i;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;
    logic        ready_o;
    logic        stallreq_o;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam int EARLY_LAT = 1;
`else
    localparam int EARLY_LAT = 33;
`endif

    ex_div dut (
        .clk         (clk),
        .rst         (rst),
        .div_start_i (div_start_i),
        .div_signed_i(div_signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .annul_i     (annul_i),
        .hold_i      (hold_i),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .ready_o     (ready_o),
        .stallreq_o  (stallreq_o)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one divide in the next cycle, scramble operands, check result at lat
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int lat,
                           input logic [31:0] eq, input logic [31:0] er);
        int early_rdy = 0;
        int stall_gap = 0;
        step();
        div_start_i  = 1'b1;
        div_signed_i = sgn;
        dividend_i   = a;
        divisor_i    = b;
        #1;
        check({tag, ":stall_accept"}, 32'(stallreq_o), 32'd1);
        check({tag, ":ready_accept"}, 32'(ready_o), 32'd0);
        for (int k = 1; k < lat; k++) begin
            step();
            if (k == 1) begin
                dividend_i   = 32'hDEAD_BEEF;
                divisor_i    = 32'h0000_0003;
                div_signed_i = ~sgn;
            end
            #1;
            if (ready_o)     early_rdy++;
            if (!stallreq_o) stall_gap++;
        end
        step();
        #1;
        check({tag, ":early_ready"}, 32'(early_rdy), 32'd0);
        check({tag, ":stall_gap"},   32'(stall_gap), 32'd0);
        check({tag, ":ready"},       32'(ready_o), 32'd1);
        check({tag, ":stall_done"},  32'(stallreq_o), 32'd0);
        check({tag, ":quotient"},    quotient_o, eq);
        check({tag, ":remainder"},   remainder_o, er);
    endtask

    // Release the result from DONE and confirm return to IDLE
    task automatic finish_done(input string tag);
        div_start_i = 1'b0;
        step();
        #1;
        check({tag, ":idle_ready"}, 32'(ready_o), 32'd0);
        check({tag, ":idle_q"},     quotient_o, 32'd0);
        check({tag, ":idle_r"},     remainder_o, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_cnt;
        rst          = 1'b1;
        div_start_i  = 1'b0;
        div_signed_i = 1'b0;
        dividend_i   = '0;
        divisor_i    = '0;
        annul_i      = 1'b0;
        hold_i       = 1'b0;

        repeat (3) step();
        #1;
        check("rst:ready", 32'(ready_o), 32'd0);
        check("rst:q",     quotient_o, 32'd0);
        check("rst:r",     remainder_o, 32'd0);
        check("rst:stall", 32'(stallreq_o), 32'd0);
        rst = 1'b0;

        // Main function, signed/unsigned, overflow, divide by zero
        run_div("u100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        finish_done("u100_7");
        run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        finish_done("s_m7_2");
        run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
        finish_done("s_7_m2");
        run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
        finish_done("s_ovf");
        run_div("u_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0);
        finish_done("u_max");
        run_div("s_z", 1'b1, 32'h0000_1234, 32'd0, 2, 32'hFFFF_FFFF, 32'h0000_1234);
        finish_done("s_z");
        run_div("u_z", 1'b0, 32'h0000_1234, 32'd0, 2, 32'hFFFF_FFFF, 32'h0000_1234);
        finish_done("u_z");
        run_div("s_z_neg", 1'b1, 32'hFFFF_FFFB, 32'd0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFB);
        finish_done("s_z_neg");

        // Divisor larger than dividend
        run_div("u5_9", 1'b0, 32'd5, 32'd9, EARLY_LAT, 32'd0, 32'd5);
        finish_done("u5_9");
        run_div("s_m3_5", 1'b1, 32'hFFFF_FFFD, 32'd5, EARLY_LAT, 32'd0, 32'hFFFF_FFFD);
        finish_done("s_m3_5");

        // Annul in the middle of a divide, then a fresh divide
        rdy_cnt = 0;
        step();
        div_start_i  = 1'b1;
        div_signed_i = 1'b0;
        dividend_i   = 32'd1000;
        divisor_i    = 32'd3;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 10) annul_i = 1'b1;
            #1;
            if (ready_o) rdy_cnt++;
        end
        check("annul:stall", 32'(stallreq_o), 32'd0);
        step();
        annul_i     = 1'b0;
        div_start_i = 1'b0;
        #1;
        if (ready_o) rdy_cnt++;
        check("annul:no_ready", 32'(rdy_cnt), 32'd0);
        run_div("post_annul", 1'b0, 32'd1000, 32'd10, 33, 32'd100, 32'd0);
        finish_done("post_annul");

        // Hold keeps the result in DONE for three extra cycles
        run_div("hold", 1'b0, 32'd50, 32'd5, 33, 32'd10, 32'd0);
        hold_i = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            step();
            if (j == 3) hold_i = 1'b0;
            #1;
            check("hold:ready", 32'(ready_o), 32'd1);
            check("hold:q",     quotient_o, 32'd10);
            check("hold:r",     remainder_o, 32'd0);
        end
        finish_done("hold");

        // Reset part way through a divide
        rdy_cnt = 0;
        step();
        div_start_i  = 1'b1;
        div_signed_i = 1'b0;
        dividend_i   = 32'd77;
        divisor_i    = 32'd7;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 5) begin
                rst         = 1'b1;
                div_start_i = 1'b0;
            end
        end
        step();
        rst = 1'b0;
        #1;
        check("mid_rst:ready", 32'(ready_o), 32'd0);
        check("mid_rst:q",     quotient_o, 32'd0);
        check("mid_rst:r",     remainder_o, 32'd0);
        check("mid_rst:stall", 32'(stallreq_o), 32'd0);
        for (int k = 0; k < 40; k++) begin
            step();
            #1;
            if (ready_o) rdy_cnt++;
        end
        check("mid_rst:no_ready", 32'(rdy_cnt), 32'd0);
        run_div("post_rst", 1'b0, 32'd77, 32'd7, 33, 32'd11, 32'd0);
        finish_done("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
